ds_adc_sequencer: RTL
=====================

# ds_adc_sequencer

Conversion sequencer for the delta-sigma ADC modulator. It gates the modulator on and generates the modulator sample strobe from a programmable divider. It discards a fixed number of settling samples, then counts the ones in the modulator bitstream over a programmable oversampling window (sinc1 decimation) and presents the result with a one-cycle valid pulse. It sits between the modulator (bitstream input, enable output) and the register/readout logic (start/abort/result).

## Interface
- `CNT_W`, 16: width of the OSR setting, the accumulator and DATA.
- `DIV_W`, 8: width of the sample-divider setting.
- `SETTLE`, 4: number of sample strobes discarded after enable (≥1).

- `CLK`  in  1: system clock, rising edge.
- `RST`  in  1: asynchronous, active-high reset.
- `START`  in  1: conversion request, sampled every cycle.
- `ABORT`  in  1: cancel the running conversion.
- `OSR`  in  CNT_W: number of counted samples per conversion; latched at accepted START.
- `DIV`  in  DIV_W: strobe period is DIV+1 clocks; latched at accepted START.
- `BIT`  in  1: modulator bitstream (the modulator DRIVE output), sampled on strobe cycles.
- `MOD_EN`  out  1: modulator enable.
- `SAMPLE`  out  1: one-cycle modulator sample strobe.
- `BUSY`  out  1: high in SETTLE and INTEG.
- `DATA`  out  CNT_W: last conversion result (count of ones).
- `VALID`  out  1: one-cycle pulse when DATA is updated.

## Operation
- FSM states: IDLE, SETTLE, INTEG, DONE. All outputs are registered.
- Reset, asynchronous: state becomes IDLE. MOD_EN, SAMPLE, BUSY, VALID = 0. DATA = 0. Divider, sample counter and accumulator = 0.
- IDLE:
  - START=1, ABORT=0 and OSR≠0 → latch OSR and DIV, clear the divider and accumulator, go to SETTLE.
  - START with OSR=0 is ignored; the FSM stays in IDLE.
- Divider: runs only in SETTLE and INTEG. It counts 0..DIV_latched, wraps, and SAMPLE=1 in the cycle the count equals DIV_latched. With DIV=0, SAMPLE is high every cycle.
- SETTLE: count strobes. After the SETTLE-th strobe, clear the sample counter and go to INTEG. BIT is ignored.
- INTEG: on each strobe cycle, acc += BIT. On the OSR_latched-th strobe, DATA ← acc + BIT, go to DONE.
- DONE: lasts one cycle with VALID=1, then returns to IDLE.
- MOD_EN = 1 in SETTLE and INTEG only.
- START while BUSY or in DONE is ignored. Changes to OSR/DIV during a conversion have no effect.
- ABORT=1 in SETTLE or INTEG → IDLE on the next edge. No VALID is issued and DATA is unchanged.
- ABORT has no effect in DONE or IDLE. If START and ABORT are both high in IDLE, ABORT wins and nothing starts.
- Width rule: the accumulator is CNT_W bits. The maximum count equals OSR ≤ 2^CNT_W−1, so no overflow or saturation is possible.

## Timing
- START accepted at edge 0 → BUSY=1 and MOD_EN=1 from cycle 1.
- The k-th strobe occurs in cycle k·(DIV+1), with k ≥ 1.
- The last counted strobe is cycle (SETTLE+OSR)·(DIV+1).
- VALID=1 and new DATA appear in cycle 1+(SETTLE+OSR)·(DIV+1). In the same cycle BUSY=0 and MOD_EN=0.
- The earliest next START is accepted in the cycle after VALID.
- ABORT seen in cycle c → BUSY, MOD_EN and SAMPLE are 0 in cycle c+1.

## Test plan
- Basic conversion: RST pulse; then DIV=0, OSR=8, SETTLE=4, BIT=1 constant, START at cycle 0 → SAMPLE every cycle 1..12, VALID only at cycle 13, DATA=8.
- Divided rate with alternating input: DIV=3, OSR=16, BIT toggling per strobe → strobes at cycles 4, 8, …, 80. VALID at cycle 81 with DATA=8. Settle strobes 1–4 are not counted: force BIT=1 during SETTLE and BIT=0 afterwards → DATA=0.
- Abort: start with OSR=100, DIV=0, assert ABORT at cycle 30 → BUSY and MOD_EN are 0 at cycle 31, no VALID, DATA keeps the previous value.
- Ignored requests:
  - Re-pulse START and change OSR to 2 mid-conversion → no effect; the result still uses the original OSR and timing.
  - START with OSR=0 → stays IDLE, BUSY stays 0.
- Full scale: CNT_W=16, OSR=65535, DIV=0, BIT=1 → DATA=65535 at cycle 65540, no wrap. Repeat with BIT=0 → DATA=0.
- Asynchronous reset mid-INTEG, asserted between clock edges → MOD_EN, BUSY and SAMPLE drop immediately and DATA=0. After release, START yields a normal conversion.

Source files
------------

// File: rtl/ds_adc_sequencer.sv
// ds_adc_sequencer: delta-sigma modulator sequencer with divided sample strobe,
// settling discard and sinc1 (ones-count) decimation over a programmable window.
module ds_adc_sequencer #(
    parameter int CNT_W  = 16,
    parameter int DIV_W  = 8,
    parameter int SETTLE = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic [CNT_W-1:0] OSR,
    input  logic [DIV_W-1:0] DIV,
    input  logic             BIT,
    output logic             MOD_EN,
    output logic             SAMPLE,
    output logic             BUSY,
    output logic [CNT_W-1:0] DATA,
    output logic             VALID
);
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_INTEG, ST_DONE} state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] div_cnt, div_n, div_l, div_l_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc, acc, acc_n, osr_l, osr_l_n, data_n;
    logic             busy_n, sample_n;

    assign cnt_inc = cnt + CNT_W'(1);

    always_comb begin
        state_n = state;
        div_l_n = div_l;
        osr_l_n = osr_l;
        cnt_n   = cnt;
        acc_n   = acc;
        data_n  = DATA;
        case (state)
            ST_IDLE:
                if (START && !ABORT && OSR != '0) begin
                    state_n = ST_SETTLE;
                    osr_l_n = OSR;
                    div_l_n = DIV;
                    cnt_n   = '0;
                    acc_n   = '0;
                end
            ST_SETTLE:
                if (ABORT) state_n = ST_IDLE;
                else if (SAMPLE) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == CNT_W'(SETTLE)) begin
                        cnt_n   = '0;
                        state_n = ST_INTEG;
                    end
                end
            ST_INTEG:
                if (ABORT) state_n = ST_IDLE;
                else if (SAMPLE) begin
                    acc_n = acc + CNT_W'(BIT);
                    cnt_n = cnt_inc;
                    if (cnt_inc == osr_l) begin
                        data_n  = acc + CNT_W'(BIT);
                        state_n = ST_DONE;
                    end
                end
            default: state_n = ST_IDLE;
        endcase
        busy_n = state_n == ST_SETTLE || state_n == ST_INTEG;
        // divider restarts from 0 on entry and free-runs across SETTLE->INTEG
        div_n    = (busy_n && BUSY) ? ((div_cnt == div_l) ? '0 : div_cnt + DIV_W'(1)) : '0;
        sample_n = busy_n && div_n == div_l_n;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            div_l   <= '0;
            osr_l   <= '0;
            cnt     <= '0;
            acc     <= '0;
            DATA    <= '0;
            MOD_EN  <= 1'b0;
            BUSY    <= 1'b0;
            SAMPLE  <= 1'b0;
            VALID   <= 1'b0;
        end else begin
            state   <= state_n;
            div_cnt <= div_n;
            div_l   <= div_l_n;
            osr_l   <= osr_l_n;
            cnt     <= cnt_n;
            acc     <= acc_n;
            DATA    <= data_n;
            MOD_EN  <= busy_n;
            BUSY    <= busy_n;
            SAMPLE  <= sample_n;
            VALID   <= state_n == ST_DONE;
        end
    end
endmodule
